vr16_imem_loader: RTL

- Boot-time program loader directly upstream of vr16_cpu.
- Receives a byte stream over a valid/ready link, assembles 16-bit big-endian instruction words and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset until a load completes successfully, then releases it.

---
 rtl/vr16_imem_loader_if.sv | 22 ++
 rtl/vr16_imem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vr16_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the vr16 boot loader.
// The slave modport is the loader side; the master modport is the stream source / memory side.
interface vr16_imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_byte;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [15:0]           imem_wdata;

  modport master (
    output in_byte, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/vr16_imem_loader.sv
// Boot-time loader: length-prefixed big-endian word stream into instruction memory, holding the CPU in reset until done.
// Optional trailing XOR checksum byte is enabled by defining VR16_LOADER_CHECKSUM_EN.
module vr16_imem_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              global_clk,
  input  logic              global_reset_n,
  input  logic              start,
  vr16_imem_loader_if.slave bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_FLUSH   = 4'd5,
    ST_DONE    = 4'd6,
    ST_ERR     = 4'd7
`ifdef VR16_LOADER_CHECKSUM_EN
    , ST_CSUM  = 4'd8
`endif
  } state_t;

  function automatic logic rx_state(input state_t s);
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: rx_state = 1'b1;
`ifdef VR16_LOADER_CHECKSUM_EN
      ST_CSUM:                                      rx_state = 1'b1;
`endif
      default:                                      rx_state = 1'b0;
    endcase
  endfunction

  state_t                state_r, state_s;
  logic                  in_ready_r, busy_r, done_r, error_r, cpu_reset_r;
  logic [1:0]            err_code_r, code_s;
  logic                  imem_we_r;
  logic [ADDR_WIDTH-1:0] imem_addr_r;
  logic [15:0]           imem_wdata_r;
  logic [7:0]            len_hi_r, hi_r;
  logic [15:0]           len_r, idx_r, len_s;
  logic [TW-1:0]         tmo_r;
  logic                  accept_s, stall_s, timeout_s, load_s, last_s;
`ifdef VR16_LOADER_CHECKSUM_EN
  logic [7:0]            csum_r;
`endif

  // Next-state and error-code decode.
  always_comb begin
    state_s   = state_r;
    code_s    = err_code_r;
    load_s    = 1'b0;
    accept_s  = in_ready_r && bus.in_valid;
    stall_s   = in_ready_r && !bus.in_valid;
    timeout_s = stall_s && (tmo_r == TMO_LAST);
    len_s     = {len_hi_r, bus.in_byte};
    last_s    = (idx_r == (len_r - 16'd1));
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_s = ST_LEN_HI;
          code_s  = 2'b00;
          load_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          state_s = ST_LEN_LO;
        end else if (timeout_s) begin
          state_s = ST_ERR;
          code_s  = 2'b10;
        end else begin
          state_s = state_r;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          if (len_s == 16'd0) begin
`ifdef VR16_LOADER_CHECKSUM_EN
            state_s = ST_CSUM;
`else
            state_s = ST_DONE;
`endif
          end else if ({1'b0, len_s} > MAX_WORDS) begin
            state_s = ST_ERR;
            code_s  = 2'b01;
          end else begin
            state_s = ST_DATA_HI;
          end
        end else if (timeout_s) begin
          state_s = ST_ERR;
          code_s  = 2'b10;
        end else begin
          state_s = state_r;
        end
      end
      ST_DATA_HI: begin
        if (accept_s) begin
          state_s = ST_DATA_LO;
        end else if (timeout_s) begin
          state_s = ST_ERR;
          code_s  = 2'b10;
        end else begin
          state_s = state_r;
        end
      end
      ST_DATA_LO: begin
        if (accept_s) begin
          if (last_s) begin
`ifdef VR16_LOADER_CHECKSUM_EN
            state_s = ST_CSUM;
`else
            state_s = ST_FLUSH;
`endif
          end else begin
            state_s = ST_DATA_HI;
          end
        end else if (timeout_s) begin
          state_s = ST_ERR;
          code_s  = 2'b10;
        end else begin
          state_s = state_r;
        end
      end
      // FLUSH covers the final write strobe so the CPU is released only afterwards.
      ST_FLUSH: state_s = ST_DONE;
`ifdef VR16_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept_s) begin
          if (bus.in_byte == csum_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ERR;
            code_s  = 2'b11;
          end
        end else if (timeout_s) begin
          state_s = ST_ERR;
          code_s  = 2'b10;
        end else begin
          state_s = state_r;
        end
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge global_clk or negedge global_reset_n) begin
    if (!global_reset_n) state_r <= ST_IDLE;
    else                 state_r <= state_s;
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge global_clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      cpu_reset_r <= 1'b1;
      err_code_r  <= 2'b00;
    end else begin
      in_ready_r  <= rx_state(state_s);
      busy_r      <= rx_state(state_s) || (state_s == ST_FLUSH);
      done_r      <= (state_s == ST_DONE);
      error_r     <= (state_s == ST_ERR);
      cpu_reset_r <= (state_s != ST_DONE);
      err_code_r  <= code_s;
    end
  end

  // Length capture, word assembly and the memory write port.
  always_ff @(posedge global_clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      len_hi_r     <= 8'h00;
      len_r        <= 16'h0000;
      hi_r         <= 8'h00;
      idx_r        <= 16'h0000;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_WIDTH{1'b0}};
      imem_wdata_r <= 16'h0000;
    end else begin
      if (accept_s && (state_r == ST_LEN_HI)) len_hi_r <= bus.in_byte;
      if (accept_s && (state_r == ST_LEN_LO)) len_r    <= len_s;
      if (accept_s && (state_r == ST_DATA_HI)) hi_r    <= bus.in_byte;
      if (load_s) begin
        idx_r <= 16'h0000;
      end else if (accept_s && (state_r == ST_DATA_LO)) begin
        idx_r <= idx_r + 16'd1;
      end
      if (accept_s && (state_r == ST_DATA_LO)) begin
        imem_we_r    <= 1'b1;
        imem_addr_r  <= idx_r[ADDR_WIDTH-1:0];
        imem_wdata_r <= {hi_r, bus.in_byte};
      end else begin
        imem_we_r    <= 1'b0;
      end
    end
  end

  // Stall counter: cleared on each accepted byte and on every state change.
  always_ff @(posedge global_clk or negedge global_reset_n) begin
    if (!global_reset_n)                        tmo_r <= {TW{1'b0}};
    else if ((state_s != state_r) || accept_s)  tmo_r <= {TW{1'b0}};
    else if (stall_s)                           tmo_r <= tmo_r + TW'(1);
    else                                        tmo_r <= tmo_r;
  end

`ifdef VR16_LOADER_CHECKSUM_EN
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Running XOR over data bytes only.
  always_ff @(posedge global_clk or negedge global_reset_n) begin
    if (!global_reset_n) csum_r <= 8'h00;
    else if (load_s)     csum_r <= 8'h00;
    else if (accept_s && ((state_r == ST_DATA_HI) || (state_r == ST_DATA_LO)))
                         csum_r <= csum_fold(csum_r, bus.in_byte);
    else                 csum_r <= csum_r;
  end
`endif

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign cpu_reset      = cpu_reset_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign err_code       = err_code_r;
endmodule
